// File: rtl/pe_pair_scheduler_pkg.sv
// ============================================================================
// pe_pair_scheduler_pkg : shared types for the PE-pair issue controller
// Rev 1.0
// ============================================================================
`default_nettype none

package pe_pair_scheduler_pkg;

    typedef enum logic [1:0] {
        COMPLEX_2_REAL = 2'd0,
        COMPLEX_ROTATE = 2'd1,
        REAL_NULLIFIED = 2'd2,
        RELATED_ROTATE = 2'd3
    } pe_scheme_e;

    localparam int PE_LAT_DEFAULT = 8;

    localparam int RP_W      = 1;
    localparam int CP_W      = 1;
    localparam int SWAP_W    = 1;
    localparam int JOB_TAG_W = RP_W + CP_W + SWAP_W;

    typedef struct packed {
        logic [RP_W-1:0]   rp;
        logic [CP_W-1:0]   cp;
        logic [SWAP_W-1:0] swap;
    } job_tag_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/pe_tag_pipe.sv
// ============================================================================
// pe_tag_pipe : DEPTH-deep valid+tag delay line matching the PE pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

module pe_tag_pipe #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    output logic [TAG_W-1:0] out_tag_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];

    always_comb begin
        valid_d[0] = in_valid_i;
        tag_d[0]   = in_tag_i;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            tag_d[i]   = tag_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign out_valid_o = valid_q[DEPTH-1];
    assign out_tag_o   = tag_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/pe_pair_scheduler.sv
// ============================================================================
// pe_pair_scheduler : scoreboard-driven issue / write-back control for PE0/PE1
// Rev 1.0
// ============================================================================
`default_nettype none

module pe_pair_scheduler
    import pe_pair_scheduler_pkg::*;
#(
    parameter int PE_LAT = PE_LAT_DEFAULT,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_rp_i,
    input  logic             req_cp_i,
    input  logic [1:0]       req_sch0_i,
    input  logic [1:0]       req_sch1_i,
    input  logic             req_swap_i,
    output logic [1:0]       pe0_valid_o,
    output logic [1:0]       pe1_valid_o,
    output logic [1:0]       pe0_scheme_o,
    output logic [1:0]       pe1_scheme_o,
    output logic             iss_rp_o,
    output logic             iss_cp_o,
    output logic             iss_swap_o,
    output logic             wb_valid_o,
    output logic             wb_rp_o,
    output logic             wb_cp_o,
    output logic             wb_swap_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] done_cnt_o
);

    logic [3:0]             busy_q, busy_d;
    sched_state_e           state_q, state_d;
    logic                   iss_valid_q, iss_valid_d;
    pe_scheme_e             sch0_q, sch0_d;
    pe_scheme_e             sch1_q, sch1_d;
    job_tag_t               iss_tag_q, iss_tag_d;
    logic [CNT_W-1:0]       done_cnt_q, done_cnt_d;

    logic                   wb_valid;
    logic [JOB_TAG_W-1:0]   wb_tag_bits;
    job_tag_t               wb_tag;
    logic [1:0]             req_idx;
    logic [1:0]             wb_idx;
    logic                   wb_hit;
    logic                   accept;

    assign wb_tag = job_tag_t'(wb_tag_bits);

    always_comb begin
        req_idx = {req_rp_i, req_cp_i};
        wb_idx  = {wb_tag.rp, wb_tag.cp};
        // A block retiring this cycle may be re-accepted in the same cycle.
        wb_hit      = wb_valid && (wb_idx == req_idx);
        req_ready_o = !rst && (!busy_q[req_idx] || wb_hit);
        accept      = req_valid_i && req_ready_o;

        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_idx] = 1'b0;
        end
        if (accept) begin
            busy_d[req_idx] = 1'b1;
        end

        iss_valid_d = accept;
        sch0_d      = sch0_q;
        sch1_d      = sch1_q;
        iss_tag_d   = iss_tag_q;
        if (accept) begin
            sch0_d         = pe_scheme_e'(req_sch0_i);
            sch1_d         = pe_scheme_e'(req_sch1_i);
            iss_tag_d.rp   = req_rp_i;
            iss_tag_d.cp   = req_cp_i;
            iss_tag_d.swap = req_swap_i;
        end

        done_cnt_d = done_cnt_q + CNT_W'(wb_valid);

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (busy_d != 4'b0000) state_d = ST_RUN;
            ST_RUN:  if (busy_d == 4'b0000) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= 4'b0000;
            state_q     <= ST_IDLE;
            iss_valid_q <= 1'b0;
            sch0_q      <= COMPLEX_2_REAL;
            sch1_q      <= COMPLEX_2_REAL;
            iss_tag_q   <= '0;
            done_cnt_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            state_q     <= state_d;
            iss_valid_q <= iss_valid_d;
            sch0_q      <= sch0_d;
            sch1_q      <= sch1_d;
            iss_tag_q   <= iss_tag_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    pe_tag_pipe #(
        .DEPTH (PE_LAT),
        .TAG_W (JOB_TAG_W)
    ) u_wb_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (iss_valid_q),
        .in_tag_i    (iss_tag_q),
        .out_valid_o (wb_valid),
        .out_tag_o   (wb_tag_bits)
    );

    assign pe0_valid_o  = {2{iss_valid_q}};
    assign pe1_valid_o  = {2{iss_valid_q}};
    assign pe0_scheme_o = sch0_q;
    assign pe1_scheme_o = sch1_q;
    assign iss_rp_o     = iss_tag_q.rp;
    assign iss_cp_o     = iss_tag_q.cp;
    assign iss_swap_o   = iss_tag_q.swap;

    // Tags are qualified so write-back fields read 0 between strobes.
    assign wb_valid_o   = wb_valid;
    assign wb_rp_o      = wb_valid & wb_tag.rp;
    assign wb_cp_o      = wb_valid & wb_tag.cp;
    assign wb_swap_o    = wb_valid & wb_tag.swap;

    assign busy_o       = (state_q == ST_RUN) || iss_valid_q;
    assign done_cnt_o   = done_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pe_pair_scheduler.sv
// ============================================================================
// tb_pe_pair_scheduler : directed checks of issue, hazard, write-back, reset
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pe_pair_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       req_valid = 1'b0, req_rp = 1'b0, req_cp = 1'b0, req_swap = 1'b0;
    logic [1:0] req_sch0 = 2'd0, req_sch1 = 2'd0;
    logic       req_ready;
    logic [1:0] pe0_valid, pe1_valid, pe0_scheme, pe1_scheme;
    logic       iss_rp, iss_cp, iss_swap;
    logic       wb_valid, wb_rp, wb_cp, wb_swap, busy;
    logic [7:0] done_cnt;

    logic       r2_valid = 1'b0, r2_rp = 1'b0, r2_cp = 1'b0;
    logic       r2_ready;
    logic [1:0] p2_v0, p2_v1, p2_s0, p2_s1;
    logic       i2_rp, i2_cp, i2_sw, w2_v, w2_rp, w2_cp, w2_sw, b2;
    logic [1:0] done2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_pair_scheduler #(.PE_LAT(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_rp_i(req_rp), .req_cp_i(req_cp),
        .req_sch0_i(req_sch0), .req_sch1_i(req_sch1), .req_swap_i(req_swap),
        .pe0_valid_o(pe0_valid), .pe1_valid_o(pe1_valid),
        .pe0_scheme_o(pe0_scheme), .pe1_scheme_o(pe1_scheme),
        .iss_rp_o(iss_rp), .iss_cp_o(iss_cp), .iss_swap_o(iss_swap),
        .wb_valid_o(wb_valid), .wb_rp_o(wb_rp), .wb_cp_o(wb_cp), .wb_swap_o(wb_swap),
        .busy_o(busy), .done_cnt_o(done_cnt)
    );

    pe_pair_scheduler #(.PE_LAT(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid_i(r2_valid), .req_ready_o(r2_ready),
        .req_rp_i(r2_rp), .req_cp_i(r2_cp),
        .req_sch0_i(2'd2), .req_sch1_i(2'd3), .req_swap_i(1'b0),
        .pe0_valid_o(p2_v0), .pe1_valid_o(p2_v1),
        .pe0_scheme_o(p2_s0), .pe1_scheme_o(p2_s1),
        .iss_rp_o(i2_rp), .iss_cp_o(i2_cp), .iss_swap_o(i2_sw),
        .wb_valid_o(w2_v), .wb_rp_o(w2_rp), .wb_cp_o(w2_cp), .wb_swap_o(w2_sw),
        .busy_o(b2), .done_cnt_o(done2)
    );

    // Advance n cycles; returns just after the falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic rp, input logic cp,
                         input logic [1:0] s0, input logic [1:0] s1, input logic sw);
        req_valid = v; req_rp = rp; req_cp = cp;
        req_sch0 = s0; req_sch1 = s1; req_swap = sw;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        total++; if (pe0_valid !== 2'b00) begin bad++; $display("FAIL reset_pe0_valid got=%b exp=00", pe0_valid); end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done_cnt !== 8'd0) begin bad++; $display("FAIL reset_done_cnt got=%0d exp=0", done_cnt); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
        rst = 1'b0;
        tick(2);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b exp=1", req_ready); end
    endtask

    task automatic test_single();
        drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", req_ready); end
        tick(1);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0);
        total++; if (pe0_valid !== 2'b11) begin bad++; $display("FAIL single_pe0_valid got=%b exp=11", pe0_valid); end
        total++; if (pe1_valid !== 2'b11) begin bad++; $display("FAIL single_pe1_valid got=%b exp=11", pe1_valid); end
        total++; if (pe0_scheme !== 2'd0) begin bad++; $display("FAIL single_pe0_scheme got=%0d exp=0", pe0_scheme); end
        total++; if (pe1_scheme !== 2'd1) begin bad++; $display("FAIL single_pe1_scheme got=%0d exp=1", pe1_scheme); end
        tick(1);
        total++; if (pe0_valid !== 2'b00) begin bad++; $display("FAIL single_pe0_valid_drop got=%b exp=00", pe0_valid); end
        total++; if (pe1_scheme !== 2'd1) begin bad++; $display("FAIL single_scheme_hold got=%0d exp=1", pe1_scheme); end
        tick(6);
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL single_wb_early got=%b exp=0", wb_valid); end
        tick(1);
        total++; if ({wb_valid, wb_rp, wb_cp} !== 3'b100) begin bad++; $display("FAIL single_wb got=%b exp=100", {wb_valid, wb_rp, wb_cp}); end
        tick(1);
        total++; if (done_cnt !== 8'd1) begin bad++; $display("FAIL single_done_cnt got=%0d exp=1", done_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy); end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL single_wb_once got=%b exp=0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            logic [1:0] blk;
            blk = 2'(i);
            drive(1'b1, blk[1], blk[0], blk, ~blk, 1'b0);
            total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready blk=%0d got=%b exp=1", i, req_ready); end
            tick(1);
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        total++; if (pe0_scheme !== 2'd3) begin bad++; $display("FAIL b2b_last_scheme got=%0d exp=3", pe0_scheme); end
        tick(5);
        for (int i = 0; i < 4; i++) begin
            logic [2:0] exp;
            exp = {1'b1, 2'(i)};
            total++; if ({wb_valid, wb_rp, wb_cp} !== exp) begin bad++; $display("FAIL b2b_wb idx=%0d got=%b exp=%b", i, {wb_valid, wb_rp, wb_cp}, exp); end
            tick(1);
        end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_wb_end got=%b exp=0", wb_valid); end
        total++; if (done_cnt !== 8'd5) begin bad++; $display("FAIL b2b_done_cnt got=%0d exp=5", done_cnt); end
    endtask

    task automatic test_hazard();
        drive(1'b1, 1'b0, 1'b0, 2'd1, 2'd2, 1'b0);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL hazard_first_ready got=%b exp=1", req_ready); end
        for (int c = 1; c <= 8; c++) begin
            tick(1);
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL hazard_stall cycle=%0d got=%b exp=0", c, req_ready); end
        end
        tick(1);
        total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL hazard_wb1 got=%b exp=1", wb_valid); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL hazard_bypass_ready got=%b exp=1", req_ready); end
        tick(1);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL hazard_set_wins got=%b exp=1", busy); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL hazard_still_busy got=%b exp=0", req_ready); end
        tick(7);
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL hazard_wb2_early got=%b exp=0", wb_valid); end
        tick(1);
        total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL hazard_wb2 got=%b exp=1", wb_valid); end
        tick(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hazard_idle got=%b exp=0", busy); end
        total++; if (done_cnt !== 8'd7) begin bad++; $display("FAIL hazard_done_cnt got=%0d exp=7", done_cnt); end
    endtask

    task automatic test_swap();
        drive(1'b1, 1'b1, 1'b0, 2'd2, 2'd3, 1'b1);
        tick(1);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        total++; if ({iss_rp, iss_cp, iss_swap} !== 3'b101) begin bad++; $display("FAIL swap_issue got=%b exp=101", {iss_rp, iss_cp, iss_swap}); end
        tick(8);
        total++; if ({wb_valid, wb_rp, wb_cp, wb_swap} !== 4'b1101) begin bad++; $display("FAIL swap_wb got=%b exp=1101", {wb_valid, wb_rp, wb_cp, wb_swap}); end
        tick(1);
        total++; if (done_cnt !== 8'd8) begin bad++; $display("FAIL swap_done_cnt got=%0d exp=8", done_cnt); end
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0); tick(1);
        drive(1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0); tick(1);
        drive(1'b1, 1'b1, 1'b0, 2'd3, 2'd2, 1'b1); tick(1);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        total++; if (pe0_valid !== 2'b11) begin bad++; $display("FAIL midrst_pre_issue got=%b exp=11", pe0_valid); end
        tick(1);
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        total++; if (done_cnt !== 8'd0) begin bad++; $display("FAIL midrst_done_cnt got=%0d exp=0", done_cnt); end
        total++; if ({pe0_scheme, pe1_scheme} !== 4'b0000) begin bad++; $display("FAIL midrst_schemes got=%b exp=0000", {pe0_scheme, pe1_scheme}); end
        total++; if ({iss_rp, iss_cp, iss_swap} !== 3'b000) begin bad++; $display("FAIL midrst_iss got=%b exp=000", {iss_rp, iss_cp, iss_swap}); end
        tick(1);
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", req_ready); end
        for (int c = 5; c <= 15; c++) begin
            total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_wb cycle=%0d got=%b exp=0", c, wb_valid); end
            tick(1);
        end
        total++; if (done_cnt !== 8'd0) begin bad++; $display("FAIL midrst_done_end got=%0d exp=0", done_cnt); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) begin
            logic [1:0] blk;
            blk = 2'(i);
            r2_valid = 1'b1; r2_rp = blk[1]; r2_cp = blk[0];
            tick(1);
        end
        r2_rp = 1'b0; r2_cp = 1'b0;
        tick(5);
        total++; if (r2_ready !== 1'b1) begin bad++; $display("FAIL wrap_fifth_ready got=%b exp=1", r2_ready); end
        tick(1);
        r2_valid = 1'b0;
        tick(2);
        total++; if (done2 !== 2'd3) begin bad++; $display("FAIL wrap_done_3 got=%0d exp=3", done2); end
        tick(1);
        total++; if (done2 !== 2'd0) begin bad++; $display("FAIL wrap_done_4 got=%0d exp=0", done2); end
        tick(6);
        total++; if (done2 !== 2'd1) begin bad++; $display("FAIL wrap_done_5 got=%0d exp=1", done2); end
    endtask

    initial begin
        test_reset();
        test_single();
        tick(2);
        test_back_to_back();
        tick(2);
        test_hazard();
        tick(2);
        test_swap();
        tick(2);
        test_reset_midflight();
        tick(2);
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
